// File: rtl/modulated_line_generator.sv
// Line-scan test-pattern generator: dark lead-in, background pixels and up to
// three square-wave modulated point sources, framed by start/stop strobes.
module modulated_line_generator #(
  parameter int         LINE_PIXELS       = 2048,
  parameter int         DARK_PIXELS_COUNT = 32,
  parameter int         PIXEL0_INDEX      = 63,
  parameter int         PIXEL1_INDEX      = 511,
  parameter int         PIXEL2_INDEX      = 1023,
  parameter int         PIXEL_DIVIDER     = 4,
  parameter logic [7:0] HIGH_LEVEL        = 8'd200,
  parameter logic [7:0] LOW_LEVEL         = 8'd20,
  parameter logic [7:0] BACKGROUND_LEVEL  = 8'd50,
  parameter logic [7:0] DARK_LEVEL        = 8'd0,
  parameter int         START_WIDTH       = 2,
  parameter int         STOP_HOLD_CYCLES  = 64
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        run,
  input  logic [31:0] half_period0,
  input  logic [31:0] half_period1,
  input  logic [31:0] half_period2,
  input  logic [15:0] burst_lines,
  output logic        pixel_clock,
  output logic [7:0]  data,
  output logic        start,
  output logic        stop,
  output logic        busy
);

  localparam int TOTAL = DARK_PIXELS_COUNT + LINE_PIXELS;
  localparam int PW    = (TOTAL > 2) ? $clog2(TOTAL) : 1;

  localparam logic [PW-1:0] LAST_POS  = PW'(TOTAL - 1);
  localparam logic [PW-1:0] DARK_END  = PW'(DARK_PIXELS_COUNT);
  localparam logic [PW-1:0] SRC0_POS  = PW'(DARK_PIXELS_COUNT + PIXEL0_INDEX);
  localparam logic [PW-1:0] SRC1_POS  = PW'(DARK_PIXELS_COUNT + PIXEL1_INDEX);
  localparam logic [PW-1:0] SRC2_POS  = PW'(DARK_PIXELS_COUNT + PIXEL2_INDEX);
  localparam logic [31:0]   HALF_M1   = 32'(PIXEL_DIVIDER / 2 - 1);
  localparam logic [31:0]   START_M1  = 32'(START_WIDTH - 1);
  localparam logic [31:0]   HOLD_M1   = 32'(STOP_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START_PULSE, STREAM, DRAIN, STOP_HOLD} state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            run_q, run_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            pclk_q, pclk_d;
  logic            busy_q, busy_d;
  logic [7:0]      data_q, data_d;
  logic [31:0]     div_q, div_d;
  logic [31:0]     seq_cnt_q, seq_cnt_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [15:0]     line_q, line_d;
  logic [15:0]     burst_q, burst_d;
  logic [2:0][31:0] hp_q, hp_d;
  logic [2:0][31:0] tog_q, tog_d;
  logic [2:0]      lvl_q, lvl_d;
  logic [2:0][31:0] hp_in;
  logic            run_rise, run_fall;

  assign hp_in = {half_period2, half_period1, half_period0};

  function automatic logic [7:0] pix_val(input logic [PW-1:0] p, input logic [2:0] lv);
    logic [7:0] v;
    v = BACKGROUND_LEVEL;
    if (p < DARK_END)       v = DARK_LEVEL;
    else if (p == SRC0_POS) v = lv[0] ? HIGH_LEVEL : LOW_LEVEL;
    else if (p == SRC1_POS) v = lv[1] ? HIGH_LEVEL : LOW_LEVEL;
    else if (p == SRC2_POS) v = lv[2] ? HIGH_LEVEL : LOW_LEVEL;
    return v;
  endfunction

  // armed_q blocks edge detection on the first clock after reset release, so a
  // run level already high at release is not mistaken for a new request
  assign run_rise = armed_q & run & ~run_q;
  assign run_fall = run_q & ~run;

  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    run_d     = run;
    start_d   = start_q;
    stop_d    = stop_q;
    pclk_d    = pclk_q;
    data_d    = data_q;
    div_d     = div_q;
    seq_cnt_d = seq_cnt_q;
    pix_d     = pix_q;
    line_d    = line_q;
    burst_d   = burst_q;
    hp_d      = hp_q;
    tog_d     = tog_q;
    lvl_d     = lvl_q;

    case (state_q)
      IDLE: begin
        if (run_rise) begin
          state_d   = START_PULSE;
          start_d   = 1'b1;
          seq_cnt_d = '0;
          hp_d      = hp_in;
          burst_d   = burst_lines;
        end
      end
      START_PULSE: begin
        if (seq_cnt_q == START_M1) begin
          state_d = STREAM;
          start_d = 1'b0;
          pclk_d  = 1'b0;
          div_d   = '0;
          pix_d   = '0;
          line_d  = '0;
          for (int k = 0; k < 3; k++) begin
            tog_d[k] = '0;
            lvl_d[k] = (hp_q[k] != '0);
          end
          data_d = pix_val('0, lvl_d);
        end else begin
          seq_cnt_d = seq_cnt_q + 32'd1;
        end
      end
      STREAM, DRAIN: begin
        for (int k = 0; k < 3; k++) begin
          if (hp_q[k] == '0) begin
            tog_d[k] = '0;
            lvl_d[k] = 1'b0;
          end else if (tog_q[k] == hp_q[k] - 32'd1) begin
            tog_d[k] = '0;
            lvl_d[k] = ~lvl_q[k];
          end else begin
            tog_d[k] = tog_q[k] + 32'd1;
          end
        end
        if (state_q == STREAM && run_fall) state_d = DRAIN;
        if (div_q == HALF_M1) begin
          div_d  = '0;
          pclk_d = ~pclk_q;
          // falling edge of pixel_clock: advance pixel and present next value
          if (pclk_q) begin
            if (pix_q == LAST_POS) begin
              pix_d  = '0;
              line_d = line_q + 16'd1;
              data_d = pix_val('0, lvl_q);
              if (state_q == DRAIN || (burst_q != '0 && line_d == burst_q)) begin
                state_d   = STOP_HOLD;
                stop_d    = 1'b1;
                data_d    = '0;
                seq_cnt_d = '0;
              end
            end else begin
              pix_d  = pix_q + 1'b1;
              data_d = pix_val(pix_d, lvl_q);
            end
          end
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      STOP_HOLD: begin
        pclk_d = 1'b0;
        data_d = '0;
        if (seq_cnt_q == HOLD_M1) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else begin
          seq_cnt_d = seq_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      run_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      pclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      div_q     <= '0;
      seq_cnt_q <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      burst_q   <= '0;
      hp_q      <= '0;
      tog_q     <= '0;
      lvl_q     <= 3'b111;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      run_q     <= run_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      pclk_q    <= pclk_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      div_q     <= div_d;
      seq_cnt_q <= seq_cnt_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      burst_q   <= burst_d;
      hp_q      <= hp_d;
      tog_q     <= tog_d;
      lvl_q     <= lvl_d;
    end
  end

  assign pixel_clock = pclk_q;
  assign data        = data_q;
  assign start       = start_q;
  assign stop        = stop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_modulated_line_generator.sv
// Directed bench for modulated_line_generator: burst framing, pixel pattern,
// source modulation, drain and restart behaviour, asynchronous reset.
module tb_modulated_line_generator;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] hp0, hp1, hp2;
  logic [15:0] bl;
  logic        pixel_clock;
  logic [7:0]  data;
  logic        start;
  logic        stop;
  logic        busy;

  int checks;
  int failures;

  modulated_line_generator dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .run            (run),
    .half_period0   (hp0),
    .half_period1   (hp1),
    .half_period2   (hp2),
    .burst_lines    (bl),
    .pixel_clock    (pixel_clock),
    .data           (data),
    .start          (start),
    .stop           (stop),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // burst monitor: sampled on the falling clock edge, cleared while mon_en=0
  logic       mon_en;
  int         cyc, n_start, n_start_pulses, n_rise, n_stop;
  int         last_start, first_rise, last_rise, first_stop, last_stop;
  int         overlap, stop_bad;
  logic       prev_pclk, prev_start;
  logic [7:0] cap [0:8447];

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0; n_start = 0; n_start_pulses = 0; n_rise = 0; n_stop = 0;
      last_start = -1; first_rise = -1; last_rise = -1;
      first_stop = -1; last_stop = -1; overlap = 0; stop_bad = 0;
      prev_pclk = 1'b0; prev_start = 1'b0;
    end else begin
      cyc++;
      if (start) begin
        n_start++;
        last_start = cyc;
        if (!prev_start) n_start_pulses++;
      end
      if (pixel_clock && !prev_pclk) begin
        if (n_rise < 8448) cap[n_rise] = data;
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
        n_rise++;
      end
      if (stop) begin
        if (first_stop < 0) first_stop = cyc;
        last_stop = cyc;
        n_stop++;
        if (pixel_clock || data != 8'd0) stop_bad++;
      end
      if (start && stop) overlap++;
      prev_pclk  = pixel_clock;
      prev_start = start;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mon_restart();
    mon_en = 1'b0;
    step();
    step();
    mon_en = 1'b1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int n;
    n = 0;
    while (!busy && n < max) begin step(); n++; end
    while (busy && n < max) begin step(); n++; end
    ok = (n < max);
  endtask

  task automatic test_reset();
    logic [11:0] v;
    run = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    checks++;
    if (busy !== 1'b0 || start !== 1'b0) begin
      failures++;
      $display("FAIL run_high_at_release: busy=%b start=%b required 0 0", busy, start);
    end
    run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      v = {pixel_clock, data, start, stop, busy};
      checks++;
      if (v !== 12'd0) begin
        failures++;
        $display("FAIL idle_outputs cycle %0d: got %h required 000", i, v);
      end
    end
  endtask

  task automatic test_single_line();
    bit ok;
    int bad_dark, bad_bg;
    hp0 = 0; hp1 = 0; hp2 = 0; bl = 16'd1;
    mon_restart();
    pulse_run();
    wait_done(20000, ok);
    step();
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: burst did not finish"); end
    checks++;
    if (n_start !== 2 || n_start_pulses !== 1) begin
      failures++;
      $display("FAIL single_start: clocks=%0d pulses=%0d required 2 1", n_start, n_start_pulses);
    end
    checks++;
    if (n_rise !== 2080) begin
      failures++; $display("FAIL single_rises: got %0d required 2080", n_rise);
    end
    bad_dark = 0; bad_bg = 0;
    for (int i = 0; i < 2080; i++) begin
      if (i < 32) begin
        if (cap[i] !== 8'd0) bad_dark++;
      end else if (i != 95 && i != 543 && i != 1055) begin
        if (cap[i] !== 8'd50) bad_bg++;
      end
    end
    checks++;
    if (bad_dark != 0 || bad_bg != 0) begin
      failures++;
      $display("FAIL single_pattern: dark errors=%0d background errors=%0d required 0 0", bad_dark, bad_bg);
    end
    checks++;
    if (cap[95] !== 8'd20 || cap[543] !== 8'd20 || cap[1055] !== 8'd20) begin
      failures++;
      $display("FAIL single_sources: got %0d %0d %0d required 20 20 20", cap[95], cap[543], cap[1055]);
    end
    checks++;
    if (n_stop !== 64 || last_stop - first_stop !== 63 || stop_bad !== 0) begin
      failures++;
      $display("FAIL single_stop: len=%0d span=%0d bad=%0d required 64 63 0", n_stop, last_stop - first_stop, stop_bad);
    end
    // STREAM entry is one clock after start drops; first rise two clocks later
    checks++;
    if (first_rise - last_start !== 3) begin
      failures++; $display("FAIL single_first_rise_gap: got %0d required 3", first_rise - last_start);
    end
    // last rise, one high sample more, then the wrap clock raises stop
    checks++;
    if (first_stop - last_rise !== 2) begin
      failures++; $display("FAIL single_stop_gap: got %0d required 2", first_stop - last_rise);
    end
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL single_overlap: got %0d required 0", overlap); end
  endtask

  task automatic test_modulation();
    bit ok;
    // pixel g is loaded at clock 4g after STREAM entry using the level after
    // clock 4g-1; level after clock n is 1 when floor(n/100) is even
    logic [7:0] exp95 [0:3];
    exp95[0] = 8'd20;  // g=95:   379  -> 3
    exp95[1] = 8'd200; // g=2175: 8699 -> 86
    exp95[2] = 8'd200; // g=4255: 17019 -> 170
    exp95[3] = 8'd20;  // g=6335: 25339 -> 253
    hp0 = 32'd100; hp1 = 0; hp2 = 0; bl = 16'd4;
    mon_restart();
    pulse_run();
    wait_done(40000, ok);
    step();
    checks++;
    if (!ok) begin failures++; $display("FAIL mod_timeout: burst did not finish"); end
    checks++;
    if (n_rise !== 8320) begin failures++; $display("FAIL mod_rises: got %0d required 8320", n_rise); end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (cap[l*2080+95] !== exp95[l]) begin
        failures++;
        $display("FAIL mod_pixel95 line %0d: got %0d required %0d", l, cap[l*2080+95], exp95[l]);
      end
    end
    checks++;
    if (cap[3*2080+543] !== 8'd20 || cap[3*2080+100] !== 8'd50 || cap[3*2080+5] !== 8'd0) begin
      failures++;
      $display("FAIL mod_line3_others: got %0d %0d %0d required 20 50 0", cap[3*2080+543], cap[3*2080+100], cap[3*2080+5]);
    end
    checks++;
    if (n_stop !== 64) begin failures++; $display("FAIL mod_stop: got %0d required 64", n_stop); end
  endtask

  task automatic test_drain();
    bit ok;
    int n;
    hp0 = 0; hp1 = 0; hp2 = 0; bl = 16'd0;
    mon_restart();
    run = 1'b1;
    n = 0;
    while (n_rise < 2*2080 + 1000 && n < 30000) begin step(); n++; end
    run = 1'b0;
    wait_done(30000, ok);
    step();
    checks++;
    if (!ok || n >= 30000) begin failures++; $display("FAIL drain_timeout: burst did not finish"); end
    checks++;
    if (n_rise !== 6240) begin failures++; $display("FAIL drain_rises: got %0d required 6240", n_rise); end
    checks++;
    if (first_stop - last_rise !== 2 || n_stop !== 64) begin
      failures++;
      $display("FAIL drain_stop: gap=%0d len=%0d required 2 64", first_stop - last_rise, n_stop);
    end
    checks++;
    if (n_start_pulses !== 1 || overlap !== 0) begin
      failures++;
      $display("FAIL drain_start: pulses=%0d overlap=%0d required 1 0", n_start_pulses, overlap);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    hp0 = 0; hp1 = 0; hp2 = 0; bl = 16'd0;
    mon_restart();
    run = 1'b1;
    n = 0;
    while (n_rise < 500 && n < 5000) begin step(); n++; end
    run = 1'b0;
    repeat (400) step();
    pulse_run();                    // during DRAIN
    while (!stop && n < 20000) begin step(); n++; end
    repeat (5) step();
    pulse_run();                    // during STOP_HOLD
    wait_done(20000, ok);
    repeat (10) step();
    checks++;
    if (!ok || n >= 20000) begin failures++; $display("FAIL b2b_timeout: burst did not finish"); end
    checks++;
    if (n_start_pulses !== 1 || n_rise !== 2080) begin
      failures++;
      $display("FAIL b2b_no_restart: pulses=%0d rises=%0d required 1 2080", n_start_pulses, n_rise);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy=%b required 0", busy); end

    // new burst: captured half_period0 keeps level 1 for the whole line even
    // though the input is cleared once the burst is under way
    hp0 = 32'd50000; bl = 16'd1;
    mon_restart();
    pulse_run();
    repeat (5) step();
    hp0 = 0;
    wait_done(20000, ok);
    step();
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b2_timeout: burst did not finish"); end
    checks++;
    if (n_start_pulses !== 1 || n_rise !== 2080 || cap[95] !== 8'd200) begin
      failures++;
      $display("FAIL b2b2_fresh: pulses=%0d rises=%0d pixel95=%0d required 1 2080 200", n_start_pulses, n_rise, cap[95]);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [11:0] v;
    int n;
    hp0 = 32'd7; hp1 = 32'd3; hp2 = 0; bl = 16'd0;
    mon_restart();
    run = 1'b1;
    n = 0;
    while (n_rise < 40 && n < 1000) begin step(); n++; end
    checks++;
    if (busy !== 1'b1 || data !== 8'd50) begin
      failures++; $display("FAIL mid_pre: busy=%b data=%0d required 1 50", busy, data);
    end
    rst_n = 1'b0;
    #1;
    v = {pixel_clock, data, start, stop, busy};
    checks++;
    if (v !== 12'd0) begin failures++; $display("FAIL mid_async_reset: got %h required 000", v); end
    run = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    v = {pixel_clock, data, start, stop, busy};
    checks++;
    if (v !== 12'd0) begin failures++; $display("FAIL mid_after_release: got %h required 000", v); end
  endtask

  initial begin
    checks = 0; failures = 0;
    mon_en = 1'b0;
    run = 1'b0; rst_n = 1'b0;
    hp0 = 0; hp1 = 0; hp2 = 0; bl = 0;
    test_reset();
    test_single_line();
    test_modulation();
    test_drain();
    test_back_to_back();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
